// File: rtl/fp_max_reduce_if.sv
// Stream bundle for fp_max_reduce: element input channel and per-vector result channel.
interface fp_max_reduce_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0]  out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count
  );
endinterface

// File: rtl/fp_max_reduce.sv
// Streaming sign-magnitude FP max reduction: one element per cycle, one result per
// in_last-terminated vector, with the element count saturating at the counter width.
module fp_max_reduce #(
  parameter int DATA_WIDTH = 32,
  parameter int EXPO_WIDTH = 8,
  parameter int MANT_WIDTH = 23,
  parameter int CNT_WIDTH  = 16
) (
  input logic             clk,
  input logic             rst,
  fp_max_reduce_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] acc_p1;
  logic [CNT_WIDTH-1:0]  cnt_p1;
  logic                  in_ready_int;
  logic                  in_fire;
  logic                  out_fire;

  // Sign-magnitude ordering: a is the incoming element, b the running maximum.
  function automatic logic [DATA_WIDTH-1:0] bigger(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic                  sa;
    logic                  sb;
    logic [EXPO_WIDTH-1:0] ea;
    logic [EXPO_WIDTH-1:0] eb;
    logic [MANT_WIDTH-1:0] ma;
    logic [MANT_WIDTH-1:0] mb;
    logic                  abs_gt;
    sa     = a[DATA_WIDTH-1];
    sb     = b[DATA_WIDTH-1];
    ea     = a[DATA_WIDTH-2 -: EXPO_WIDTH];
    eb     = b[DATA_WIDTH-2 -: EXPO_WIDTH];
    ma     = a[MANT_WIDTH-1:0];
    mb     = b[MANT_WIDTH-1:0];
    abs_gt = (ea > eb) | ((ea == eb) & (ma > mb));
    case ({sa, sb})
      2'b00:   bigger = abs_gt ? a : b;
      2'b01:   bigger = a;
      2'b10:   bigger = b;
      default: bigger = abs_gt ? b : a;
    endcase
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    sat_inc = (c == CNT_MAX) ? CNT_MAX : c + CNT_ONE;
  endfunction

  assign in_ready_int  = (state != DONE) & ~rst;
  assign in_fire       = bus.in_valid & in_ready_int;
  assign out_fire      = (state == DONE) & bus.out_ready;

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = acc_p1;
  assign bus.out_count = cnt_p1;

  // Stage p1: running maximum and element count, updated once per accepted element
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc_p1 <= '0;
      cnt_p1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            acc_p1 <= bus.in_data;
            cnt_p1 <= CNT_ONE;
            state  <= bus.in_last ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            acc_p1 <= bigger(bus.in_data, acc_p1);
            cnt_p1 <= sat_inc(cnt_p1);
            if (bus.in_last) state <= DONE;
          end
        end
        DONE: begin
          // acc is left holding the old result; it is overwritten by the next first beat
          if (out_fire) begin
            cnt_p1 <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_max_reduce.sv
// Directed bench for fp_max_reduce: a key-ordered max model checked every cycle,
// plus literal expectations on reset, handshake and per-vector results.
module tb_fp_max_reduce;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  fp_max_reduce_if #(.DATA_WIDTH(32), .CNT_WIDTH(CNT_W)) bus ();

  fp_max_reduce #(
    .DATA_WIDTH(32), .EXPO_WIDTH(8), .MANT_WIDTH(23), .CNT_WIDTH(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  // Monotonic key: larger key means larger value under sign-magnitude ordering,
  // with +0 above -0.
  function automatic logic [31:0] order_key(input logic [31:0] v);
    order_key = v[31] ? ~v : (v | 32'h8000_0000);
  endfunction

  logic [31:0] exp_data_q[$];
  int          exp_cnt_q[$];
  logic [31:0] log_data_q[$];
  int          log_cnt_q[$];
  logic [31:0] part_best;
  int          part_n = 0;

  always @(negedge clk) begin
    if (rst) begin
      check("in_ready_in_rst", {31'b0, bus.in_ready}, 32'd0);
      check("out_valid_in_rst", {31'b0, bus.out_valid}, 32'd0);
      part_n = 0;
      exp_data_q.delete();
      exp_cnt_q.delete();
    end else begin
      check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_data_q.size() > 0});
      if (exp_data_q.size() > 0 && bus.out_valid) begin
        check("out_data", bus.out_data, exp_data_q[0]);
        check("out_count", {28'b0, bus.out_count}, exp_cnt_q[0]);
        if (bus.out_ready) begin
          log_data_q.push_back(bus.out_data);
          log_cnt_q.push_back(int'(bus.out_count));
          void'(exp_data_q.pop_front());
          void'(exp_cnt_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (part_n == 0 || order_key(bus.in_data) > order_key(part_best))
          part_best = bus.in_data;
        part_n++;
        if (bus.in_last) begin
          exp_data_q.push_back(part_best);
          exp_cnt_q.push_back(part_n > CNT_MAX ? CNT_MAX : part_n);
          part_n = 0;
        end
      end
    end
  end

  // Driver tasks start and end just after a rising edge.
  task automatic send(input logic [31:0] d, input logic last);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeout_fail("in_ready_wait");
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic gap(input int n);
    bus.in_last = 1'b1;  // stray last without valid must be ignored
    repeat (n) @(posedge clk);
    #1;
    bus.in_last = 1'b0;
  endtask

  logic [31:0] vec_q[$];

  task automatic send_vec(input int gap_n);
    for (int i = 0; i < vec_q.size(); i++) begin
      send(vec_q[i], i == vec_q.size() - 1);
      if (gap_n > 0 && i != vec_q.size() - 1) gap(gap_n);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_data_q.size() > 0 || bus.out_valid) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) timeout_fail("drain");
    @(posedge clk);
    #1;
  endtask

  logic [31:0] lit_data[10] = '{32'h4000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000,
                                32'h7F80_0000, 32'h4000_0000, 32'hBF00_0000, 32'h3F80_0000,
                                32'h4000_0013, 32'h0000_0000};
  int          lit_cnt[10]  = '{3, 3, 3, 2, 1, 2, 1, 1, 15, 0};

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_out_data", bus.out_data, 32'd0);
      check("rst_out_count", {28'b0, bus.out_count}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;

    vec_q = '{32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000};
    send_vec(0);
    @(negedge clk);
    check("v1_latency_valid", {31'b0, bus.out_valid}, 32'd1);
    check("v1_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    drain();

    vec_q = '{32'hBF80_0000, 32'hC040_0000, 32'h8000_0000};
    send_vec(0);
    drain();
    vec_q = '{32'hC040_0000, 32'h0000_0000, 32'hBF80_0000};
    send_vec(0);
    drain();
    vec_q = '{32'h8000_0000, 32'h0000_0000};
    send_vec(0);
    drain();

    bus.out_ready = 1'b0;
    send(32'h7F80_0000, 1'b1);
    repeat (5) begin
      @(negedge clk);
      check("hold_valid", {31'b0, bus.out_valid}, 32'd1);
      check("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
      check("hold_data", bus.out_data, 32'h7F80_0000);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("release_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    #1;

    vec_q = '{32'h4000_0000, 32'h3F80_0000};
    send_vec(2);
    vec_q = '{32'hBF00_0000};
    send_vec(0);
    drain();

    send(32'h3F80_0000, 1'b0);
    send(32'h4000_0000, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("postrst_out_data", bus.out_data, 32'd0);
    check("postrst_out_count", {28'b0, bus.out_count}, 32'd0);
    check("postrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    vec_q = '{32'h3F80_0000};
    send_vec(0);
    drain();

    vec_q.delete();
    for (int i = 0; i < 20; i++) vec_q.push_back(32'h4000_0000 + 32'((i * 7) % 20));
    send_vec(0);
    drain();

    check("log_size", log_data_q.size(), 32'd9);
    for (int k = 0; k < 9; k++) begin
      if (k < log_data_q.size()) begin
        check($sformatf("lit_data_%0d", k), log_data_q[k], lit_data[k]);
        check($sformatf("lit_count_%0d", k), log_cnt_q[k], lit_cnt[k]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
